// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives inst_mem and captures the returned word into IF/ID.
// Latency: the instruction at pc appears on if_id_instr one edge after pc is presented.
// Backpressure: a load-use stall holds the PC and IF/ID; a redirect overrides a stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      instruction,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc4,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       if_id_pc_q, if_id_pc_d;
  logic [31:0]       if_id_pc4_q, if_id_pc4_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

  logic [31:0]       pc_plus4;
  logic              redirect;
  logic [31:0]       redirect_pc;

  // Redirect target selection: a taken branch beats a jump; targets are forced to word alignment.
  always_comb begin
    pc_plus4    = pc_q + 32'd4;
    redirect    = branch_taken | jump;
    redirect_pc = (branch_taken ? branch_target : jump_target) & ~32'h3;
  end

  // Next-state and datapath: redirect > stall > flush > sequential, only outside BOOT.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      BOOT: begin
        // One idle cycle after reset: PC held, IF/ID remains the reset bubble.
        state_d = RUN;
      end
      default: begin
        if (redirect) begin
          // Wrong-path instruction is squashed even when a stall is pending.
          state_d       = RUN;
          pc_d          = redirect_pc;
          if_id_pc_d    = 32'h0;
          if_id_pc4_d   = 32'h0;
          if_id_instr_d = 32'h0;
          if_id_valid_d = 1'b0;
        end else if (stall) begin
          // Hold everything; a concurrent flush must not destroy the stalled instruction.
          state_d = HOLD;
        end else if (flush) begin
          state_d       = RUN;
          pc_d          = pc_plus4;
          if_id_pc_d    = 32'h0;
          if_id_pc4_d   = 32'h0;
          if_id_instr_d = 32'h0;
          if_id_valid_d = 1'b0;
        end else begin
          state_d       = RUN;
          pc_d          = pc_plus4;
          if_id_pc_d    = pc_q;
          if_id_pc4_d   = pc_plus4;
          if_id_instr_d = instruction;
          if_id_valid_d = 1'b1;
          if (fetch_count_q != {CNT_W{1'b1}}) begin
            fetch_count_d = fetch_count_q + 1'b1;
          end
        end
      end
    endcase
  end

  // State and pipeline registers with synchronous active-low reset that overrides everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'h0;
      if_id_pc4_q   <= 32'h0;
      if_id_instr_q <= 32'h0;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus, expected captures queued and checked by a monitor.
// Latency: captures are observed on the falling edge after the capturing rising edge.
// Backpressure: stall/redirect cases are checked directly from the stimulus thread.
module tb_fetch_stage;

  localparam logic [31:0] R0 = 32'h2008_0005;
  localparam logic [31:0] R1 = 32'h2009_000A;
  localparam logic [31:0] R2 = 32'h0109_5020;
  localparam logic [31:0] R3 = 32'hAC0A_0000;
  localparam logic [31:0] R4 = 32'h8C0B_0000;
  localparam logic [31:0] R5 = 32'h016A_6022;
  localparam logic [31:0] R6 = 32'h1000_0002;
  localparam logic [31:0] R7 = 32'h0800_0003;
  localparam logic [31:0] R8 = 32'h2108_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [15:0] fetch_count;

  logic [31:0] rom [0:15];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  fetch_stage #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .instruction  (instruction),
    .pc           (pc),
    .if_id_pc     (if_id_pc),
    .if_id_pc4    (if_id_pc4),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory model: 16 words at address 0, nop (0) everywhere else.
  always_comb begin
    instruction = 32'h0;
    if (pc[31:6] == 26'h0) instruction = rom[pc[5:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i);
    exp_t e;
    e.pc    = p;
    e.instr = i;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string name);
    chk({name, "_valid"}, 32'(if_id_valid), 32'h0);
    chk({name, "_instr"}, if_id_instr, 32'h0);
    chk({name, "_ifpc"}, if_id_pc, 32'h0);
  endtask

  // Monitor: each new valid capture (fetch_count advances by one) pops one expected entry.
  initial begin
    logic [15:0] last_cnt;
    exp_t        e;
    last_cnt = 16'h0;
    forever begin
      @(negedge clk);
      if (fetch_count !== last_cnt) begin
        if (if_id_valid === 1'b1 && fetch_count == last_cnt + 16'd1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_capture", if_id_pc, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            chk("cap_pc", if_id_pc, e.pc);
            chk("cap_pc4", if_id_pc4, e.pc + 32'd4);
            chk("cap_instr", if_id_instr, e.instr);
          end
        end
        last_cnt = fetch_count;
      end
    end
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    rom[0] = R0; rom[1] = R1; rom[2] = R2; rom[3] = R3; rom[4] = R4;
    rom[5] = R5; rom[6] = R6; rom[7] = R7; rom[8] = R8;

    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0;

    // Reset held for three edges.
    step(); step(); step();
    chk("rst_pc", pc, 32'h0);
    chk_bubble("rst");
    chk("rst_cnt", 32'(fetch_count), 32'h0);

    // Release: BOOT cycle keeps pc and bubble.
    reset = 1'b1;
    step();
    chk("boot_pc", pc, 32'h0);
    chk("boot_valid", 32'(if_id_valid), 32'h0);

    // First capture on the second edge after release, then pc 4.
    push(32'h0, R0); step();
    chk("run_pc4", pc, 32'h4);
    push(32'h4, R1); step();
    chk("run_pc8", pc, 32'h8);

    // Stall two cycles at pc=8, second cycle also asserts flush which must be ignored.
    stall = 1'b1; step();
    flush = 1'b1; step();
    chk("stall_pc", pc, 32'h8);
    chk("stall_ifpc", if_id_pc, 32'h4);
    chk("stall_instr", if_id_instr, R1);
    chk("stall_valid", 32'(if_id_valid), 32'h1);
    chk("stall_cnt", 32'(fetch_count), 32'h2);
    stall = 1'b0; flush = 1'b0;

    // Resume at pc=8.
    push(32'h8, R2); step();
    chk("resume_pc", pc, 32'hC);

    // Taken branch at pc=12 to unaligned 0x1E -> 0x1C, IF/ID bubble.
    branch_taken = 1'b1; branch_target = 32'h1E; step();
    branch_taken = 1'b0;
    chk("br_pc", pc, 32'h1C);
    chk_bubble("br");
    chk("br_cnt", 32'(fetch_count), 32'h3);
    push(32'h1C, R7); step();
    chk("after_br_cnt", 32'(fetch_count), 32'h4);
    chk("after_br_pc", pc, 32'h20);

    // Jump together with stall: redirect wins.
    stall = 1'b1; jump = 1'b1; jump_target = 32'h4; step();
    stall = 1'b0; jump = 1'b0;
    chk("jstall_pc", pc, 32'h4);
    chk_bubble("jstall");
    push(32'h4, R1); step();
    chk("jstall_run_pc", pc, 32'h8);

    // Branch and jump together: branch target taken.
    branch_taken = 1'b1; branch_target = 32'h20; jump = 1'b1; jump_target = 32'h4; step();
    branch_taken = 1'b0; jump = 1'b0;
    chk("bj_pc", pc, 32'h20);
    chk("bj_valid", 32'(if_id_valid), 32'h0);
    push(32'h20, R8); step();

    // Fetch at top of address space: out-of-range nop captured valid, pc wraps to 0.
    jump = 1'b1; jump_target = 32'hFFFF_FFFC; step();
    jump = 1'b0;
    chk("top_pc", pc, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC, 32'h0); step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_valid", 32'(if_id_valid), 32'h1);
    chk("wrap_cnt", 32'(fetch_count), 32'h7);

    // Enter HOLD at pc=0x10, then reset during the stall.
    jump = 1'b1; jump_target = 32'h10; step();
    jump = 1'b0; stall = 1'b1;
    step(); step();
    chk("hold_pc", pc, 32'h10);
    reset = 1'b0; step();
    chk("rst2_pc", pc, 32'h0);
    chk_bubble("rst2");
    chk("rst2_cnt", 32'(fetch_count), 32'h0);
    reset = 1'b1; stall = 1'b0; step();
    chk("boot2_pc", pc, 32'h0);
    chk("boot2_valid", 32'(if_id_valid), 32'h0);
    push(32'h0, R0); step();
    chk("boot2_run_pc", pc, 32'h4);

    // Plain flush: pc advances, IF/ID bubbles, count unchanged.
    flush = 1'b1; step();
    flush = 1'b0;
    chk("flush_pc", pc, 32'h8);
    chk_bubble("flush");
    chk("flush_cnt", 32'(fetch_count), 32'h1);
    push(32'h8, R2); step();

    // Park in HOLD and let the monitor drain.
    stall = 1'b1;
    step(); step(); step();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
